// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
//   sel_w(n)      : width of a channel index, max(1, $clog2(n))
//   lock_state_e  : packet-lock FSM states (used only when packet lock is built in)
package mux_pkg;

    function automatic int sel_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req [N-1:0]  : request vector
//   ptr [SW-1:0] : index of the last granted channel; search starts at ptr+1
//   gnt [N-1:0]  : one-hot grant (all zero when nothing requests)
//   idx [SW-1:0] : encoded index of the granted channel (0 when no grant)
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = sel_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx
);

    logic found;

    // The rotating search is split into two ascending passes: channels above
    // ptr first, then channels from 0 up to ptr. The first hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional code; otherwise an unassigned path infers a latch.
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i > int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = SW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i <= int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = SW'(i);
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel, W-bit valid/ready stream multiplexer with round-robin arbitration
// and a registered output stage (one beat per cycle, 1-cycle latency).
// Optional build macro: MUX_RR_PKT_LOCK_EN -- once a channel starts a packet
// it keeps the grant until its in_last beat is accepted.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_last [N]    : per-channel valid and end-of-packet
//   in_data [N*W]           : channel i at bits [i*W +: W]
//   in_ready [N]            : per-channel ready, at most one bit high
//   out_valid/out_data/out_last/out_sel : registered output beat and source index
//   out_ready               : sink ready
module mux_rr_stream
    import mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int SW = sel_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_sel,
    input  logic            out_ready
);

    logic [SW-1:0] ptr;
    logic          ld;
    logic          take;
    logic          ptr_upd;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [SW-1:0] gnt_idx;
    logic [W-1:0]  sel_data;
    logic          sel_last;

    // The output register can accept a new beat when empty or being drained.
    assign ld   = !out_valid || out_ready;
    assign take = ld && (|gnt);
    // Held low during reset so no producer sees a handshake that is discarded.
    assign in_ready = rst ? '0 : (gnt & {N{ld}});

    rr_arbiter #(.N(N)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // One-hot AND-OR mux; avoids a variable part-select on the flattened bus.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_data = sel_data | in_data[i*W +: W];
                sel_last = sel_last | in_last[i];
            end
        end
    end

`ifdef MUX_RR_PKT_LOCK_EN
    lock_state_e   state, state_d;
    logic [SW-1:0] lock_ch, lock_ch_d;

    // While locked, every channel except the packet owner is masked out.
    always_comb begin
        req = in_valid;
        if (state == LOCK) begin
            for (int i = 0; i < N; i++) begin
                if (SW'(i) != lock_ch) req[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB;
            lock_ch <= '0;
        end else begin
            state   <= state_d;
            lock_ch <= lock_ch_d;
        end
    end

    always_comb begin
        state_d   = state;
        lock_ch_d = lock_ch;
        case (state)
            ARB: begin
                if (take && !sel_last) begin
                    state_d   = LOCK;
                    lock_ch_d = gnt_idx;
                end
            end
            LOCK: begin
                if (take && sel_last) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    // Fairness advances per packet, not per beat.
    assign ptr_upd = take && sel_last;
`else
    assign req     = in_valid;
    assign ptr_upd = take;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            ptr       <= SW'(N - 1);
        end else begin
            if (ld) begin
                if (take) begin
                    out_valid <= 1'b1;
                    out_data  <= sel_data;
                    out_last  <= sel_last;
                    out_sel   <= gnt_idx;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (ptr_upd) ptr <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
module tb_mux_rr_stream;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [1:0]     out_sel;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_rr_stream #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic         ordy;
        logic [N-1:0] exp_ready;
        logic         exp_ov;
        logic [1:0]   exp_sel;
        logic [W-1:0] exp_data;
        logic         exp_last;
    } vec_t;

    vec_t vecs[16];

    localparam logic [N*W-1:0] CH_DATA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [1:0] sel,
                             input logic [W-1:0] data, input logic last);
        check({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, " out_sel"},   32'(out_sel),   32'(sel));
        check({tag, " out_data"},  32'(out_data),  32'(data));
        check({tag, " out_last"},  32'(out_last),  32'(last));
    endtask

    logic [1:0]   pk_sel [4];
    logic [W-1:0] pk_data[4];
    logic         pk_last[4];
    int           beat;

    initial begin
        //             valid    ordy  ready    ov    sel   data   last
        vecs[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1, 1'b1};
        vecs[3]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1};
        vecs[4]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1};
        vecs[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0, 1'b1};
        // ch2/ch3 with a three-cycle sink stall after ch2's beat
        vecs[7]  = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b1};
        vecs[8]  = '{4'b1100, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2, 1'b1};
        vecs[9]  = '{4'b1100, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2, 1'b1};
        vecs[10] = '{4'b1100, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2, 1'b1};
        vecs[11] = '{4'b1100, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3, 1'b1};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hA3, 1'b1};
        // ptr = 3 with ch0 and ch3 requesting: wrap-around to ch0
        vecs[13] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0, 1'b1};
        vecs[14] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 8'hA0, 1'b1};
        vecs[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'hA0, 1'b1};

        // Reset with every channel valid: in_ready must stay low throughout.
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = CH_DATA;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("ready in reset", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 4'b0000;
        check_out("reset", 1'b0, 2'd0, 8'h00, 1'b0);

        for (int k = 0; k < 16; k++) begin
            in_valid  = vecs[k].valid;
            out_ready = vecs[k].ordy;
            #1;
            check($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vecs[k].exp_ready));
            @(posedge clk); #1;
            check_out($sformatf("v%0d", k), vecs[k].exp_ov, vecs[k].exp_sel,
                      vecs[k].exp_data, vecs[k].exp_last);
        end

        // ptr is 0 here. ch1 sends a 3-beat packet while ch0 and ch2 stay valid.
`ifdef MUX_RR_PKT_LOCK_EN
        pk_sel  = '{2'd1, 2'd1, 2'd1, 2'd2};
        pk_data = '{8'h11, 8'h12, 8'h13, 8'hA2};
        pk_last = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
        pk_sel  = '{2'd1, 2'd2, 2'd0, 2'd1};
        pk_data = '{8'h11, 8'hA2, 8'hA0, 8'h12};
        pk_last = '{1'b0, 1'b1, 1'b1, 1'b0};
`endif
        beat      = 1;
        in_valid  = 4'b0111;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data[1*W +: W] = W'(8'h10 + beat);
            in_last           = (beat == 3) ? 4'b1111 : 4'b1101;
            @(posedge clk); #1;
            check_out($sformatf("pkt%0d", k), 1'b1, pk_sel[k], pk_data[k], pk_last[k]);
            if (pk_sel[k] == 2'd1) beat++;
        end

        // Leave ch1 mid-packet with a held beat, then reset during a stall.
        in_data           = CH_DATA;
        in_data[1*W +: W] = 8'h55;
        in_last           = 4'b1101;
        in_valid          = 4'b0010;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pre-reset out_valid", 32'(out_valid), 32'h1);
        rst      = 1'b1;
        in_valid = 4'b1111;
        #1;
        check("ready in mid reset", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        check("post-reset out_valid", 32'(out_valid), 32'h0);
        rst       = 1'b0;
        in_data   = CH_DATA;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'h1);
        @(posedge clk); #1;
        check_out("post-reset arb", 1'b1, 2'd0, 8'hA0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
